// File: rtl/pcm_iec60958_framer.sv
// Frames the 128fs PCM stream into IEC 60958 stereo subframes (24-bit audio, V, U, C, P)
// with a 192-frame block counter, handed downstream over a valid/ready holding register.
module pcm_iec60958_framer #(
  parameter logic [3:0] CS_FS_CODE = 4'h0,
  parameter logic [3:0] CS_WORDLEN = 4'h2,
  parameter logic       CS_COPY    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pcm_fs,
  input  logic [15:0] pcm_ldata,
  input  logic [15:0] pcm_rdata,
  input  logic        pcm_mute,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [27:0] out_left,
  output logic [27:0] out_right,
  output logic        out_b,
  output logic        overrun
);

  logic        fs_q;
  logic        valid_q, valid_d;
  logic [27:0] left_q, left_d;
  logic [27:0] right_q, right_d;
  logic        b_q, b_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  idx_q, idx_d;
  logic        fs_rise;
  logic        slot_free;
  logic        cs_bit;

  // Layout {P, C, U, V, audio}; P makes the whole 28-bit word even parity.
  function automatic logic [27:0] build_subframe(input logic [15:0] sample,
                                                 input logic        mute,
                                                 input logic        c_bit);
    logic [26:0] body;
    body = {c_bit, 2'b00, (mute ? 24'h000000 : {sample, 8'h00})};
    return {^body, body};
  endfunction

  // Channel-status ROM: only bit 2 and the nibbles at 24..27 and 32..35 can be non-zero.
  always_comb begin
    cs_bit = 1'b0;
    if (idx_q == 8'd2) begin
      cs_bit = CS_COPY;
    end else if (idx_q[7:2] == 6'd6) begin
      cs_bit = CS_FS_CODE[idx_q[1:0]];
    end else if (idx_q[7:2] == 6'd8) begin
      cs_bit = CS_WORDLEN[idx_q[1:0]];
    end
  end

  always_comb begin
    fs_rise   = pcm_fs & ~fs_q & enable;
    slot_free = ~valid_q | out_ready;

    valid_d = valid_q & ~out_ready;
    left_d  = left_q;
    right_d = right_q;
    b_d     = b_q;
    ovr_d   = ovr_q;
    idx_d   = idx_q;

    if (fs_rise && slot_free) begin
      valid_d = 1'b1;
      left_d  = build_subframe(pcm_ldata, pcm_mute, cs_bit);
      right_d = build_subframe(pcm_rdata, pcm_mute, cs_bit);
      b_d     = (idx_q == 8'd0);
      idx_d   = (idx_q == 8'd191) ? 8'd0 : idx_q + 8'd1;
    end else if (fs_rise) begin
      ovr_d = 1'b1;
    end

    // Disabling restarts the block; a frame already in the holding register still drains.
    if (!enable) begin
      idx_d = 8'd0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fs_q    <= 1'b0;
      valid_q <= 1'b0;
      left_q  <= 28'h0;
      right_q <= 28'h0;
      b_q     <= 1'b0;
      ovr_q   <= 1'b0;
      idx_q   <= 8'd0;
    end else begin
      fs_q    <= pcm_fs;
      valid_q <= valid_d;
      left_q  <= left_d;
      right_q <= right_d;
      b_q     <= b_d;
      ovr_q   <= ovr_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q;
  assign out_left  = left_q;
  assign out_right = right_q;
  assign out_b     = b_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pcm_iec60958_framer.sv
// Bench for pcm_iec60958_framer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a frame-level behavioural model.
module tb_pcm_iec60958_framer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        pcm_fs = 1'b0;
  logic [15:0] pcm_ldata = 16'h0;
  logic [15:0] pcm_rdata = 16'h0;
  logic        pcm_mute = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [27:0] out_left;
  logic [27:0] out_right;
  logic        out_b;
  logic        overrun;

  pcm_iec60958_framer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pcm_fs    (pcm_fs),
    .pcm_ldata (pcm_ldata),
    .pcm_rdata (pcm_rdata),
    .pcm_mute  (pcm_mute),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_left  (out_left),
    .out_right (out_right),
    .out_b     (out_b),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] k_fs_code = 4'h0;
  logic [3:0] k_wordlen = 4'h2;

  function automatic logic cs_rule(input int i);
    if (i == 2) return 1'b1;
    if (i >= 24 && i <= 27) return k_fs_code[i-24];
    if (i >= 32 && i <= 35) return k_wordlen[i-32];
    return 1'b0;
  endfunction

  function automatic logic [27:0] subframe(input logic [15:0] d, input logic m, input logic c);
    logic [23:0] audio;
    logic [26:0] w;
    audio = m ? 24'd0 : {d, 8'd0};
    w = {c, 1'b0, 1'b0, audio};
    return {1'($countones(w) % 2), w};
  endfunction

  bit          m_init = 0;
  logic        m_valid = 0, m_ovr = 0, m_b = 0, m_prev_fs = 0;
  logic [27:0] m_left = 0, m_right = 0;
  int          m_idx = 0;

  task automatic model_step();
    bit rise, taken;
    if (!reset_n) begin
      m_init = 1; m_valid = 0; m_ovr = 0; m_b = 0; m_prev_fs = 0;
      m_left = 0; m_right = 0; m_idx = 0;
    end else begin
      rise  = pcm_fs && !m_prev_fs && enable;
      taken = m_valid && out_ready;
      if (rise && (!m_valid || taken)) begin
        m_left  = subframe(pcm_ldata, pcm_mute, cs_rule(m_idx));
        m_right = subframe(pcm_rdata, pcm_mute, cs_rule(m_idx));
        m_b     = (m_idx == 0);
        m_valid = 1;
        m_idx   = (m_idx + 1) % 192;
      end else begin
        if (taken) m_valid = 0;
        if (rise) m_ovr = 1;
      end
      if (!enable) begin
        m_idx = 0;
        m_ovr = 0;
      end
      m_prev_fs = pcm_fs;
    end
  endtask

  // Frame capture of what the DUT hands over, for the directed literal checks.
  bit          cap_en = 0;
  int          cap_n = 0;
  logic [27:0] cap_left[256];
  logic [27:0] cap_right[256];
  logic        cap_b[256];

  always @(posedge clk) begin
    model_step();
    #3;
    if (m_init)
      check("cycle", {5'd0, out_valid, overrun, out_b, out_left, out_right},
            {5'd0, m_valid, m_ovr, m_b, m_left, m_right});
    if (cap_en && out_valid && out_ready && cap_n < 256) begin
      cap_left[cap_n]  = out_left;
      cap_right[cap_n] = out_right;
      cap_b[cap_n]     = out_b;
      cap_n++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pcm_fs  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic m);
    @(negedge clk);
    pcm_fs = 1'b1; pcm_ldata = l; pcm_rdata = r; pcm_mute = m;
    @(negedge clk);
    pcm_fs = 1'b0;
    pcm_ldata = 16'($urandom); pcm_rdata = 16'($urandom); pcm_mute = 1'($urandom);
  endtask

  int ones_b, ones_c, bad_par, fs_cnt, en_off;

  initial begin
    // First frame latency and literal subframe encoding.
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    pcm_fs = 1'b1; pcm_ldata = 16'h8000; pcm_rdata = 16'h0001; pcm_mute = 1'b0;
    check("t1_valid_before_edge", 64'(out_valid), 64'd0);
    @(negedge clk);
    pcm_fs = 1'b0;
    check("t1_valid_after_1clk", 64'(out_valid), 64'd1);
    check("t1_left", 64'(out_left), 64'h8800000);
    check("t1_right", 64'(out_right), 64'h8000100);
    check("t1_b", 64'(out_b), 64'd1);
    @(negedge clk);

    // Block structure over 195 zero-data frames.
    do_reset();
    cap_n = 0; cap_en = 1;
    repeat (195) send_frame(16'h0, 16'h0, 1'b0);
    @(negedge clk);
    cap_en = 0;
    check("t2_frames", 64'(cap_n), 64'd195);
    ones_b = 0; ones_c = 0; bad_par = 0;
    for (int i = 0; i < 195; i++) begin
      ones_b += int'(cap_b[i]);
      ones_c += int'(cap_left[i][26]);
      if (cap_left[i][27] != cap_left[i][26] || cap_right[i] != cap_left[i]) bad_par++;
    end
    check("t2_b_frame0", 64'(cap_b[0]), 64'd1);
    check("t2_b_frame192", 64'(cap_b[192]), 64'd1);
    check("t2_b_count", 64'(ones_b), 64'd2);
    check("t2_c_frame2", 64'(cap_left[2][26]), 64'd1);
    check("t2_c_frame33", 64'(cap_left[33][26]), 64'd1);
    check("t2_c_frame194", 64'(cap_left[194][26]), 64'd1);
    check("t2_c_count", 64'(ones_c), 64'd3);
    check("t2_parity_eq_c", 64'(bad_par), 64'd0);

    // Mute at frame 5.
    do_reset();
    cap_n = 0; cap_en = 1;
    repeat (5) send_frame(16'($urandom), 16'($urandom), 1'b0);
    send_frame(16'h7FFF, 16'hFFFF, 1'b1);
    send_frame(16'h0, 16'h0, 1'b0);
    @(negedge clk);
    cap_en = 0;
    check("t3_frames", 64'(cap_n), 64'd7);
    check("t3_left", 64'(cap_left[5]), 64'h0);
    check("t3_right", 64'(cap_right[5]), 64'h0);
    check("t3_b", 64'(cap_b[5]), 64'd0);

    // Backpressure: one frame held, one dropped, no index skip afterwards.
    do_reset();
    send_frame(16'h0, 16'h0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(16'h0100, 16'h0, 1'b0);
    send_frame(16'h0200, 16'h0, 1'b0);
    @(negedge clk);
    check("t4_valid_held", 64'(out_valid), 64'd1);
    check("t4_overrun", 64'(overrun), 64'd1);
    check("t4_left_held", 64'(out_left), 64'h8010000);
    out_ready = 1'b1;
    @(negedge clk);
    send_frame(16'h0, 16'h0, 1'b0);
    check("t4_next_left", 64'(out_left), 64'hC000000);
    check("t4_next_b", 64'(out_b), 64'd0);
    check("t4_overrun_sticky", 64'(overrun), 64'd1);
    @(negedge clk);

    // Disable mid-block with a pending frame and an overrun.
    do_reset();
    repeat (100) send_frame(16'($urandom), 16'($urandom), 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 1'b0);
    send_frame(16'h3333, 16'h4444, 1'b0);
    @(negedge clk);
    check("t5_overrun_set", 64'(overrun), 64'd1);
    enable = 1'b0;
    repeat (3) send_frame(16'h5555, 16'h6666, 1'b0);
    check("t5_pending_valid", 64'(out_valid), 64'd1);
    check("t5_overrun_clear", 64'(overrun), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_drained", 64'(out_valid), 64'd0);
    enable = 1'b1;
    send_frame(16'h0, 16'h0, 1'b0);
    check("t5_reenable_b", 64'(out_b), 64'd1);
    @(negedge clk);

    // Reset mid-stream with a pending frame.
    out_ready = 1'b0;
    send_frame(16'h1234, 16'h5678, 1'b0);
    send_frame(16'h1234, 16'h5678, 1'b0);
    do_reset();
    check("t6_valid_cleared", 64'(out_valid), 64'd0);
    check("t6_overrun_cleared", 64'(overrun), 64'd0);
    out_ready = 1'b1;
    send_frame(16'h0, 16'h0, 1'b0);
    check("t6_first_b", 64'(out_b), 64'd1);
    @(negedge clk);

    // Randomized run against the model.
    fs_cnt = 0; en_off = 0;
    repeat (4000) begin
      @(negedge clk);
      if (fs_cnt == 0) begin
        pcm_fs = ~pcm_fs;
        fs_cnt = $urandom_range(1, 5);
      end else begin
        fs_cnt--;
      end
      pcm_ldata = 16'($urandom);
      pcm_rdata = 16'($urandom);
      pcm_mute  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if (en_off == 0 && $urandom_range(0, 1499) == 0) en_off = $urandom_range(1, 20);
      enable = (en_off == 0);
      if (en_off > 0) en_off--;
      reset_n = ($urandom_range(0, 1999) != 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
